flush_control_n_t: RTL and testbench

FLUSH_CONTROL_N_T -- requirements
Module: flush_control_n_t

---
 rtl/flush_control_n_t.sv | 133 +++++++++++++
 tb/tb_flush_control_n_t.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/flush_control_n_t.sv
// Pipeline flush/clear control: per-lane age-aware stage clears, an IF shadow
// stall after any redirect, and a saturating count of redirect cycles.
module flush_control_n_t #(
  parameter int LANES  = 2,
  parameter int AW     = 2,
  parameter int SHADOW = 1,
  parameter int CW     = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ACT,
  input  logic                  s_if_jump_Q,
  input  logic                  s_ex_pcsrc_Q,
  input  logic                  s_me_pcsrc_Q,
  input  logic [LANES-1:0]      s_id_pcsrc_Q,
  input  logic [LANES-1:0]      s_ex_pcsrc_v_Q,
  input  logic [LANES-1:0]      s_me_pcsrc_v_Q,
  input  logic [LANES-1:0]      s_id_stall_Q,
  input  logic [LANES-1:0]      s_ex_stall_Q,
  input  logic [LANES-1:0]      s_me_stall_Q,
  input  logic [LANES*AW-1:0]   s_id_age_Q,
  input  logic [LANES*AW-1:0]   s_ex_age_Q,
  input  logic [LANES*AW-1:0]   s_me_age_Q,
  input  logic                  perf_clr,
  output logic                  s_id_clear_D,
  output logic                  s_if_stall_D,
  output logic [LANES-1:0]      s_ex_clear_D,
  output logic [LANES-1:0]      s_me_clear_D,
  output logic [LANES-1:0]      s_wb_clear_D,
  output logic [LANES-1:0]      r_id_stall_Q,
  output logic                  r_id_clear_Q,
  output logic [CW-1:0]         flush_cnt,
  output logic                  dbg_state_o,
  output logic [3:0]            dbg_sh_cnt_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHADOW = 1'b1} state_e;

  localparam logic [3:0] SH_LOAD = 4'(SHADOW);

  state_e          state_q, state_d;
  logic [3:0]      sh_cnt_q, sh_cnt_d;
  logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [LANES-1:0] r_id_stall_q;
  logic            r_id_clear_q;
  logic            redir;

  // Lane i is cleared when some other lane j with a strictly older tag redirects.
  function automatic logic [LANES-1:0] older_clr(input logic [LANES-1:0]    pc,
                                                 input logic [LANES*AW-1:0] age);
    logic [LANES-1:0] res;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (j != i && pc[j] && (age[j*AW +: AW] < age[i*AW +: AW])) res[i] = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    s_id_clear_D = ACT & s_if_jump_Q;
    s_ex_clear_D = {LANES{ACT}} & ({LANES{s_me_pcsrc_Q | s_ex_pcsrc_Q}} | s_id_stall_Q |
                                   older_clr(s_id_pcsrc_Q, s_id_age_Q));
    s_me_clear_D = {LANES{ACT}} & ({LANES{s_me_pcsrc_Q}} | s_ex_stall_Q |
                                   older_clr(s_ex_pcsrc_v_Q, s_ex_age_Q));
    s_wb_clear_D = {LANES{ACT}} & (s_me_stall_Q | older_clr(s_me_pcsrc_v_Q, s_me_age_Q));
    redir = ACT & (s_me_pcsrc_Q | s_ex_pcsrc_Q | (|s_id_pcsrc_Q) |
                   (|s_ex_pcsrc_v_Q) | (|s_me_pcsrc_v_Q));
  end

  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (redir && (SHADOW > 0)) begin
          state_d  = ST_SHADOW;
          sh_cnt_d = SH_LOAD;
        end
      end
      ST_SHADOW: begin
        if (redir) begin
          sh_cnt_d = SH_LOAD;
        end else if (ACT) begin
          if (sh_cnt_q <= 4'd1) begin
            sh_cnt_d = 4'd0;
            state_d  = ST_IDLE;
          end else begin
            sh_cnt_d = sh_cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sh_cnt_d = 4'd0;
      end
    endcase
  end

  // Clear wins over a simultaneous redirect; the counter sticks at all-ones.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) flush_cnt_d = '0;
    else if (redir && (flush_cnt_q != {CW{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      sh_cnt_q     <= 4'd0;
      flush_cnt_q  <= '0;
      r_id_stall_q <= '0;
      r_id_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_cnt_q    <= sh_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (ACT) begin
        r_id_stall_q <= s_id_stall_Q;
        r_id_clear_q <= s_id_clear_D;
      end
    end
  end

  assign s_if_stall_D = (state_q == ST_SHADOW);
  assign r_id_stall_Q = r_id_stall_q;
  assign r_id_clear_Q = r_id_clear_q;
  assign flush_cnt    = flush_cnt_q;
  assign dbg_state_o  = state_q;
  assign dbg_sh_cnt_o = sh_cnt_q;

endmodule

// File: tb/tb_flush_control_n_t.sv
// Bench for flush_control_n_t: directed scenarios plus randomized cycles, all
// checked against a cycle-level reference model of the clear/stall/count rules.
module tb_flush_control_n_t;

  localparam int LANES  = 2;
  localparam int AW     = 1;
  localparam int SHADOW = 2;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic              CLK, RST, ACT, s_if_jump_Q, s_ex_pcsrc_Q, s_me_pcsrc_Q, perf_clr;
  logic [LANES-1:0]  s_id_pcsrc_Q, s_ex_pcsrc_v_Q, s_me_pcsrc_v_Q;
  logic [LANES-1:0]  s_id_stall_Q, s_ex_stall_Q, s_me_stall_Q;
  logic [LANES*AW-1:0] s_id_age_Q, s_ex_age_Q, s_me_age_Q;
  logic              s_id_clear_D, s_if_stall_D, r_id_clear_Q, dbg_state_o;
  logic [LANES-1:0]  s_ex_clear_D, s_me_clear_D, s_wb_clear_D, r_id_stall_Q;
  logic [CW-1:0]     flush_cnt;
  logic [3:0]        dbg_sh_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stall cycles still owed, redirect-cycle count, ID copies.
  int               m_stall_left;
  int               m_fcnt;
  logic [LANES-1:0] m_r_id_stall;
  logic             m_r_id_clear;

  flush_control_n_t #(.LANES(LANES), .AW(AW), .SHADOW(SHADOW), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .ACT(ACT), .s_if_jump_Q(s_if_jump_Q),
    .s_ex_pcsrc_Q(s_ex_pcsrc_Q), .s_me_pcsrc_Q(s_me_pcsrc_Q),
    .s_id_pcsrc_Q(s_id_pcsrc_Q), .s_ex_pcsrc_v_Q(s_ex_pcsrc_v_Q), .s_me_pcsrc_v_Q(s_me_pcsrc_v_Q),
    .s_id_stall_Q(s_id_stall_Q), .s_ex_stall_Q(s_ex_stall_Q), .s_me_stall_Q(s_me_stall_Q),
    .s_id_age_Q(s_id_age_Q), .s_ex_age_Q(s_ex_age_Q), .s_me_age_Q(s_me_age_Q),
    .perf_clr(perf_clr), .s_id_clear_D(s_id_clear_D), .s_if_stall_D(s_if_stall_D),
    .s_ex_clear_D(s_ex_clear_D), .s_me_clear_D(s_me_clear_D), .s_wb_clear_D(s_wb_clear_D),
    .r_id_stall_Q(r_id_stall_Q), .r_id_clear_Q(r_id_clear_Q), .flush_cnt(flush_cnt),
    .dbg_state_o(dbg_state_o), .dbg_sh_cnt_o(dbg_sh_cnt_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Clear mask from "some other lane with a strictly smaller tag redirected".
  function automatic logic [LANES-1:0] m_older(input logic [LANES-1:0] pc,
                                               input logic [LANES*AW-1:0] age);
    logic [LANES-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      for (int j = 0; j < LANES; j++) begin
        int ai, aj;
        ai = int'((age >> (i*AW)) & ((1 << AW) - 1));
        aj = int'((age >> (j*AW)) & ((1 << AW) - 1));
        if (i != j && pc[j] && aj < ai) r[i] = 1'b1;
      end
    return r;
  endfunction

  function automatic logic m_redir();
    return ACT & (s_me_pcsrc_Q | s_ex_pcsrc_Q | (|s_id_pcsrc_Q) |
                  (|s_ex_pcsrc_v_Q) | (|s_me_pcsrc_v_Q));
  endfunction

  task automatic check_comb();
    logic [LANES-1:0] e_ex, e_me, e_wb;
    e_ex = '0; e_me = '0; e_wb = '0;
    if (ACT) begin
      e_ex = {LANES{s_me_pcsrc_Q | s_ex_pcsrc_Q}} | s_id_stall_Q | m_older(s_id_pcsrc_Q, s_id_age_Q);
      e_me = {LANES{s_me_pcsrc_Q}} | s_ex_stall_Q | m_older(s_ex_pcsrc_v_Q, s_ex_age_Q);
      e_wb = s_me_stall_Q | m_older(s_me_pcsrc_v_Q, s_me_age_Q);
    end
    chk("id_clear", 16'(s_id_clear_D), 16'(ACT & s_if_jump_Q));
    chk("ex_clear", 16'(s_ex_clear_D), 16'(e_ex));
    chk("me_clear", 16'(s_me_clear_D), 16'(e_me));
    chk("wb_clear", 16'(s_wb_clear_D), 16'(e_wb));
  endtask

  task automatic check_regs();
    chk("if_stall", 16'(s_if_stall_D), 16'(m_stall_left > 0));
    chk("flush_cnt", 16'(flush_cnt), 16'(m_fcnt));
    chk("r_id_stall", 16'(r_id_stall_Q), 16'(m_r_id_stall));
    chk("r_id_clear", 16'(r_id_clear_Q), 16'(m_r_id_clear));
  endtask

  task automatic model_reset();
    m_stall_left = 0; m_fcnt = 0; m_r_id_stall = '0; m_r_id_clear = 1'b0;
  endtask

  // Apply the cycle's inputs (already driven), check comb, clock, check regs.
  task automatic cycle();
    logic rd;
    #1 check_comb();
    rd = m_redir();
    @(posedge CLK);
    if (ACT) begin
      m_r_id_stall = s_id_stall_Q;
      m_r_id_clear = s_if_jump_Q;
    end
    if (rd) m_stall_left = SHADOW;
    else if (ACT && m_stall_left > 0) m_stall_left--;
    if (perf_clr) m_fcnt = 0;
    else if (rd && m_fcnt < CMAX) m_fcnt++;
    #1 check_regs();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    ACT = 1'b1; s_if_jump_Q = 0; s_ex_pcsrc_Q = 0; s_me_pcsrc_Q = 0; perf_clr = 0;
    s_id_pcsrc_Q = '0; s_ex_pcsrc_v_Q = '0; s_me_pcsrc_v_Q = '0;
    s_id_stall_Q = '0; s_ex_stall_Q = '0; s_me_stall_Q = '0;
    s_id_age_Q = '0; s_ex_age_Q = '0; s_me_age_Q = '0;
  endtask

  task automatic drain();
    idle_inputs();
    perf_clr = 1'b1;
    cycle();
    perf_clr = 1'b0;
    for (int k = 0; k < SHADOW + 1; k++) cycle();
  endtask

  initial begin
    idle_inputs();
    RST = 1'b0;
    model_reset();
    #2 check_regs();
    check_comb();
    @(negedge CLK);
    RST = 1'b1;
    cycle();

    // Age-ordered ID clears
    s_id_pcsrc_Q = 2'b01; s_id_age_Q = 2'b10;
    #1 chk("old_id_lane1", 16'(s_ex_clear_D), 16'h2);
    cycle();
    s_id_age_Q = 2'b01;
    #1 chk("young_id_none", 16'(s_ex_clear_D), 16'h0);
    cycle();
    drain();

    // Single ME redirect and its shadow
    s_me_pcsrc_Q = 1'b1;
    #1 chk("me_redir_ex", 16'(s_ex_clear_D), 16'h3);
    chk("me_redir_me", 16'(s_me_clear_D), 16'h3);
    cycle();
    s_me_pcsrc_Q = 1'b0;
    chk("stall_t1", 16'(s_if_stall_D), 16'h1);
    cycle();
    chk("stall_t2", 16'(s_if_stall_D), 16'h1);
    cycle();
    chk("stall_t3", 16'(s_if_stall_D), 16'h0);
    chk("flush_one", 16'(flush_cnt), 16'h1);
    drain();

    // Redirect at t and t+2
    s_ex_pcsrc_Q = 1'b1; cycle();
    s_ex_pcsrc_Q = 1'b0; chk("rr_t1", 16'(s_if_stall_D), 16'h1); cycle();
    chk("rr_t2", 16'(s_if_stall_D), 16'h1);
    s_ex_pcsrc_v_Q = 2'b10; cycle();
    s_ex_pcsrc_v_Q = 2'b00; chk("rr_t3", 16'(s_if_stall_D), 16'h1); cycle();
    chk("rr_t4", 16'(s_if_stall_D), 16'h1); cycle();
    chk("rr_t5", 16'(s_if_stall_D), 16'h0);
    chk("flush_two", 16'(flush_cnt), 16'h2);
    drain();

    // Saturation and clear priority
    s_me_pcsrc_v_Q = 2'b01;
    for (int k = 0; k < 16; k++) cycle();
    chk("flush_sat", 16'(flush_cnt), 16'hf);
    cycle();
    chk("flush_sat_hold", 16'(flush_cnt), 16'hf);
    perf_clr = 1'b1; cycle();
    chk("flush_clr_prio", 16'(flush_cnt), 16'h0);
    perf_clr = 1'b0; s_me_pcsrc_v_Q = '0;

    // ACT=0 holds everything
    s_id_stall_Q = 2'b10; s_if_jump_Q = 1'b1; s_me_pcsrc_Q = 1'b1; cycle();
    ACT = 1'b0; s_if_jump_Q = 1; s_ex_pcsrc_Q = 1; s_me_pcsrc_Q = 1;
    s_id_pcsrc_Q = '1; s_ex_pcsrc_v_Q = '1; s_me_pcsrc_v_Q = '1;
    s_id_stall_Q = '1; s_ex_stall_Q = '1; s_me_stall_Q = '1;
    s_id_age_Q = '1; s_ex_age_Q = '1; s_me_age_Q = '1;
    #1 chk("act0_clears", 16'({s_id_clear_D, s_ex_clear_D, s_me_clear_D, s_wb_clear_D}), 16'h0);
    for (int k = 0; k < 3; k++) cycle();
    chk("act0_stall_hold", 16'(s_if_stall_D), 16'h1);
    chk("act0_rstall_hold", 16'(r_id_stall_Q), 16'h2);
    chk("act0_flush_hold", 16'(flush_cnt), 16'h1);
    idle_inputs();

    // Reset in the shadow window
    s_me_pcsrc_Q = 1'b1; cycle();
    s_me_pcsrc_Q = 1'b0;
    chk("pre_rst_stall", 16'(s_if_stall_D), 16'h1);
    #2 RST = 1'b0;
    #1 chk("rst_drops_stall", 16'(s_if_stall_D), 16'h0);
    model_reset();
    @(negedge CLK);
    check_regs();
    RST = 1'b1;
    s_id_stall_Q = 2'b11; cycle();
    chk("rid_stall_load", 16'(r_id_stall_Q), 16'h3);
    chk("post_rst_idle", 16'(s_if_stall_D), 16'h0);

    // Randomized cycles
    for (int k = 0; k < 400; k++) begin
      ACT            = ($urandom_range(0, 7) != 0);
      s_if_jump_Q    = $urandom_range(0, 1);
      s_ex_pcsrc_Q   = ($urandom_range(0, 5) == 0);
      s_me_pcsrc_Q   = ($urandom_range(0, 5) == 0);
      perf_clr       = ($urandom_range(0, 31) == 0);
      s_id_pcsrc_Q   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      s_ex_pcsrc_v_Q = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      s_me_pcsrc_v_Q = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      s_id_stall_Q   = 2'($urandom_range(0, 3));
      s_ex_stall_Q   = 2'($urandom_range(0, 3));
      s_me_stall_Q   = 2'($urandom_range(0, 3));
      s_id_age_Q     = 2'($urandom_range(0, 3));
      s_ex_age_Q     = 2'($urandom_range(0, 3));
      s_me_age_Q     = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
